// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: steers MiSTer ioctl downloads into the Blue Print ROM map.
// Runs entirely in the download clock domain. Index 0 carries the main CPU,
// tile and sprite ROMs; index 1 carries the sound board ROMs. Produces
// registered write strobes for the EPROM banks, tracks which 4 KB main
// regions are complete, validates image sizes and keeps the game CPUs in
// reset until a full ROM set has been loaded.
`timescale 1ns/1ps

module rom_dl_ctrl #(
    parameter int MAIN_SIZE   = 'hA000,
    parameter int SND_SIZE    = 'h2000,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        main_wr,
    output logic        snd_wr,
    output logic [9:0]  region_done,
    output logic        main_ok,
    output logic        snd_ok,
    output logic        load_err,
    output logic        cpu_reset_hold
);

    localparam logic [16:0] MAIN_COUNT = 17'(MAIN_SIZE);
    localparam logic [16:0] SND_COUNT  = 17'(SND_SIZE);
    localparam logic [24:0] MAIN_LIMIT = 25'(MAIN_SIZE);
    localparam logic [24:0] SND_LIMIT  = 25'(SND_SIZE);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_MAIN,
        LOAD_SND,
        CHECK
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_dl_q;
    logic        r_is_snd;
    logic [16:0] r_byte_count;
    logic [3:0]  r_wait_count;

    logic        w_dl_rise;
    logic        w_dl_fall;
    logic        w_loading;
    logic        w_wr_sampled;
    logic        w_in_range;
    logic        w_accept;
    logic        w_reject;
    logic        w_start_main;
    logic        w_start_snd;
    logic        w_check_pass;
    logic        w_main_wr_next;
    logic        w_snd_wr_next;

    // Edge detection and byte classification shared by every process below.
    // The registered copy of ioctl_download powers up high so that a download
    // already in progress across a reset is never mistaken for a fresh start.
    assign w_dl_rise    = ioctl_download & ~r_dl_q;
    assign w_dl_fall    = ~ioctl_download & r_dl_q;
    assign w_loading    = (r_state == LOAD_MAIN) | (r_state == LOAD_SND);
    assign w_wr_sampled = w_loading & ioctl_wr;
    assign w_in_range   = (r_state == LOAD_MAIN) ? (ioctl_addr < MAIN_LIMIT)
                                                 : (ioctl_addr < SND_LIMIT);
    assign w_accept     = w_wr_sampled & ~ioctl_wait & w_in_range;
    assign w_reject     = w_wr_sampled & ~w_accept;
    assign w_start_main = (r_state == IDLE) & w_dl_rise & (ioctl_index == 8'd0);
    assign w_start_snd  = (r_state == IDLE) & w_dl_rise & (ioctl_index == 8'd1);
    assign w_check_pass = (r_byte_count == (r_is_snd ? SND_COUNT : MAIN_COUNT)) & ~load_err;

    assign ioctl_wait     = (r_wait_count != 4'd0);
    assign cpu_reset_hold = ~(main_ok & snd_ok) | ioctl_download;

    // State register for the download sequencer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the strobe each accepted byte should raise next cycle.
    always_comb begin
        w_next_state   = r_state;
        w_main_wr_next = 1'b0;
        w_snd_wr_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_main) begin
                    w_next_state = LOAD_MAIN;
                end else if (w_start_snd) begin
                    w_next_state = LOAD_SND;
                end
            end
            LOAD_MAIN: begin
                w_main_wr_next = w_accept;
                if (w_dl_fall) begin
                    w_next_state = CHECK;
                end
            end
            LOAD_SND: begin
                w_snd_wr_next = w_accept;
                if (w_dl_fall) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered copy of ioctl_download and the index that opened the current load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dl_q   <= 1'b1;
            r_is_snd <= 1'b0;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_start_main) begin
                r_is_snd <= 1'b0;
            end else if (w_start_snd) begin
                r_is_snd <= 1'b1;
            end
        end
    end

    // Write port towards the EPROM banks: one-cycle strobes with address and data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            main_wr  <= 1'b0;
            snd_wr   <= 1'b0;
            rom_addr <= 25'd0;
            rom_data <= 8'd0;
        end else begin
            main_wr <= w_main_wr_next;
            snd_wr  <= w_snd_wr_next;
            if (w_wr_sampled) begin
                rom_addr <= ioctl_addr;
                rom_data <= ioctl_dout;
            end
        end
    end

    // Saturating count of every byte the HPS presented during the current load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_byte_count <= 17'd0;
        end else if (w_start_main || w_start_snd) begin
            r_byte_count <= 17'd0;
        end else if (w_wr_sampled && (r_byte_count != 17'h1FFFF)) begin
            r_byte_count <= r_byte_count + 17'd1;
        end
    end

    // Stall the HPS for a fixed number of cycles after each byte that was written.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wait_count <= 4'd0;
        end else if (w_accept) begin
            r_wait_count <= WAIT_LOAD;
        end else if (r_wait_count != 4'd0) begin
            r_wait_count <= r_wait_count - 4'd1;
        end
    end

    // Completion and error bookkeeping; the error flag survives a sound reload
    // and is only cleared when the main image is loaded again.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            region_done <= 10'd0;
            main_ok     <= 1'b0;
            snd_ok      <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            if (w_start_main) begin
                region_done <= 10'd0;
                main_ok     <= 1'b0;
                load_err    <= 1'b0;
            end else if (w_start_snd) begin
                snd_ok <= 1'b0;
            end
            if (w_accept && (r_state == LOAD_MAIN) && (ioctl_addr[11:0] == 12'hFFF)) begin
                region_done <= region_done | (10'd1 << ioctl_addr[15:12]);
            end
            if (w_reject) begin
                load_err <= 1'b1;
            end
            if (r_state == CHECK) begin
                if (w_check_pass) begin
                    if (r_is_snd) begin
                        snd_ok <= 1'b1;
                    end else begin
                        main_ok <= 1'b1;
                    end
                end else begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb_rom_dl_ctrl: scoreboard bench for rom_dl_ctrl. Two instances share the
// ioctl stimulus: dut0 paces with no wait cycles, dut3 with three. Every byte
// expected to reach the EPROM port is queued with the cycle its strobe is due;
// a monitor pops and compares on each strobe of the selected instance.
`timescale 1ns/1ps

module tb_rom_dl_ctrl;

    typedef struct {
        logic        isSnd;
        logic [24:0] addr;
        logic [7:0]  data;
        int          due;
    } wrRec_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        ioctlDownload;
    logic [7:0]  ioctlIndex;
    logic        ioctlWr;
    logic [24:0] ioctlAddr;
    logic [7:0]  ioctlDout;

    logic        d0Wait, d0MainWr, d0SndWr, d0MainOk, d0SndOk, d0LoadErr, d0Hold;
    logic [24:0] d0RomAddr;
    logic [7:0]  d0RomData;
    logic [9:0]  d0RegionDone;

    logic        d3Wait, d3MainWr, d3SndWr, d3MainOk, d3SndOk, d3LoadErr, d3Hold;
    logic [24:0] d3RomAddr;
    logic [7:0]  d3RomData;
    logic [9:0]  d3RegionDone;

    logic        monSel = 1'b0;
    logic        monMain, monSnd;
    logic [24:0] monAddr;
    logic [7:0]  monData;

    wrRec_t      expQ[$];
    wrRec_t      rec;
    int          cycleCnt = 0;
    int          checkCount = 0;
    int          errorCount = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    rom_dl_ctrl #(.MAIN_SIZE('hA000), .SND_SIZE('h2000), .WAIT_CYCLES(0)) dut0 (
        .CLK(clock), .RESET_N(resetN), .ioctl_download(ioctlDownload),
        .ioctl_index(ioctlIndex), .ioctl_wr(ioctlWr), .ioctl_addr(ioctlAddr),
        .ioctl_dout(ioctlDout), .ioctl_wait(d0Wait), .rom_addr(d0RomAddr),
        .rom_data(d0RomData), .main_wr(d0MainWr), .snd_wr(d0SndWr),
        .region_done(d0RegionDone), .main_ok(d0MainOk), .snd_ok(d0SndOk),
        .load_err(d0LoadErr), .cpu_reset_hold(d0Hold)
    );

    rom_dl_ctrl #(.MAIN_SIZE('hA000), .SND_SIZE('h2000), .WAIT_CYCLES(3)) dut3 (
        .CLK(clock), .RESET_N(resetN), .ioctl_download(ioctlDownload),
        .ioctl_index(ioctlIndex), .ioctl_wr(ioctlWr), .ioctl_addr(ioctlAddr),
        .ioctl_dout(ioctlDout), .ioctl_wait(d3Wait), .rom_addr(d3RomAddr),
        .rom_data(d3RomData), .main_wr(d3MainWr), .snd_wr(d3SndWr),
        .region_done(d3RegionDone), .main_ok(d3MainOk), .snd_ok(d3SndOk),
        .load_err(d3LoadErr), .cpu_reset_hold(d3Hold)
    );

    assign monMain = monSel ? d3MainWr  : d0MainWr;
    assign monSnd  = monSel ? d3SndWr   : d0SndWr;
    assign monAddr = monSel ? d3RomAddr : d0RomAddr;
    assign monData = monSel ? d3RomData : d0RomData;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cycleCnt);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] rndByte();
        return 8'($urandom_range(0, 255));
    endfunction

    // Present one byte; queue the strobe it should cause one cycle later.
    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                                 input bit expectWr, input bit isSnd);
        wrRec_t r;
        ioctlWr   = 1'b1;
        ioctlAddr = addr;
        ioctlDout = data;
        if (expectWr) begin
            r.isSnd = isSnd;
            r.addr  = addr;
            r.data  = data;
            r.due   = cycleCnt + 1;
            expQ.push_back(r);
        end
        tick();
    endtask

    task automatic startDownload(input logic [7:0] idx);
        ioctlIndex    = idx;
        ioctlWr       = 1'b0;
        ioctlDownload = 1'b1;
        tick();
    endtask

    task automatic applyReset();
        resetN = 1'b0;
        ioctlDownload = 1'b0;
        ioctlWr = 1'b0;
        repeat (2) tick();
        checkOutput("rst_wait", 64'(d0Wait), 64'(0));
        checkOutput("rst_main_wr", 64'(d0MainWr), 64'(0));
        checkOutput("rst_snd_wr", 64'(d0SndWr), 64'(0));
        checkOutput("rst_rom_addr", 64'(d0RomAddr), 64'(0));
        checkOutput("rst_rom_data", 64'(d0RomData), 64'(0));
        checkOutput("rst_region_done", 64'(d0RegionDone), 64'(0));
        checkOutput("rst_main_ok", 64'(d0MainOk), 64'(0));
        checkOutput("rst_snd_ok", 64'(d0SndOk), 64'(0));
        checkOutput("rst_load_err", 64'(d0LoadErr), 64'(0));
        checkOutput("rst_hold", 64'(d0Hold), 64'(1));
        checkOutput("rst_wait_dut3", 64'(d3Wait), 64'(0));
        resetN = 1'b1;
        repeat (2) tick();
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clock) begin
        if (monMain || monSnd) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", 64'({monMain, monSnd}), 64'(0));
            end else begin
                rec = expQ.pop_front();
                checkOutput("strobe_kind", 64'({monMain, monSnd}), rec.isSnd ? 64'(2'b01) : 64'(2'b10));
                checkOutput("strobe_latency", 64'(cycleCnt), 64'(rec.due));
                checkOutput("strobe_addr", 64'(monAddr), 64'(rec.addr));
                checkOutput("strobe_data", 64'(monData), 64'(rec.data));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN        = 1'b0;
        ioctlDownload = 1'b0;
        ioctlIndex    = 8'd0;
        ioctlWr       = 1'b0;
        ioctlAddr     = 25'd0;
        ioctlDout     = 8'd0;
        applyReset();

        // Full main image, back-to-back bytes.
        startDownload(8'd0);
        for (int i = 0; i < 'hA000; i++) begin
            if (i % 4096 == 0) checkOutput("hold_during_main", 64'(d0Hold), 64'(1));
            applyStimulus(25'(i), rndByte(), 1'b1, 1'b0);
        end
        ioctlWr = 1'b0;
        ioctlDownload = 1'b0;
        tick();
        checkOutput("main_ok_in_check", 64'(d0MainOk), 64'(0));
        tick();
        checkOutput("main_ok_full", 64'(d0MainOk), 64'(1));
        checkOutput("region_done_full", 64'(d0RegionDone), 64'(10'h3FF));
        checkOutput("load_err_full", 64'(d0LoadErr), 64'(0));
        checkOutput("hold_main_only", 64'(d0Hold), 64'(1));

        // Sound image; the last byte arrives with the falling edge of download.
        startDownload(8'd1);
        for (int i = 0; i < 'h2000; i++) begin
            if (i == 'h1FFF) ioctlDownload = 1'b0;
            applyStimulus(25'(i), rndByte(), 1'b1, 1'b1);
        end
        ioctlWr = 1'b0;
        checkOutput("snd_ok_in_check", 64'(d0SndOk), 64'(0));
        checkOutput("hold_in_check", 64'(d0Hold), 64'(1));
        tick();
        checkOutput("snd_ok_full", 64'(d0SndOk), 64'(1));
        checkOutput("main_ok_kept", 64'(d0MainOk), 64'(1));
        checkOutput("hold_released", 64'(d0Hold), 64'(0));

        // Unknown index: nothing written, status untouched.
        startDownload(8'd2);
        checkOutput("hold_idx2_active", 64'(d0Hold), 64'(1));
        for (int i = 0; i < 16; i++) applyStimulus(25'(i), rndByte(), 1'b0, 1'b0);
        ioctlWr = 1'b0;
        ioctlDownload = 1'b0;
        repeat (3) tick();
        checkOutput("idx2_main_ok", 64'(d0MainOk), 64'(1));
        checkOutput("idx2_snd_ok", 64'(d0SndOk), 64'(1));
        checkOutput("idx2_region_done", 64'(d0RegionDone), 64'(10'h3FF));
        checkOutput("idx2_load_err", 64'(d0LoadErr), 64'(0));
        checkOutput("idx2_hold", 64'(d0Hold), 64'(0));

        // Short main image.
        startDownload(8'd0);
        checkOutput("short_region_cleared", 64'(d0RegionDone), 64'(0));
        for (int i = 0; i < 'h5000; i++) applyStimulus(25'(i), rndByte(), 1'b1, 1'b0);
        ioctlWr = 1'b0;
        ioctlDownload = 1'b0;
        repeat (2) tick();
        checkOutput("short_region_done", 64'(d0RegionDone), 64'(10'h01F));
        checkOutput("short_main_ok", 64'(d0MainOk), 64'(0));
        checkOutput("short_load_err", 64'(d0LoadErr), 64'(1));
        checkOutput("short_hold", 64'(d0Hold), 64'(1));

        // Out-of-range byte just past the main map.
        startDownload(8'd0);
        checkOutput("oor_err_cleared", 64'(d0LoadErr), 64'(0));
        applyStimulus(25'h0000, rndByte(), 1'b1, 1'b0);
        applyStimulus(25'h9FFF, rndByte(), 1'b1, 1'b0);
        applyStimulus(25'hA000, rndByte(), 1'b0, 1'b0);
        ioctlWr = 1'b0;
        checkOutput("oor_load_err", 64'(d0LoadErr), 64'(1));
        ioctlDownload = 1'b0;
        repeat (2) tick();
        checkOutput("oor_region_done", 64'(d0RegionDone), 64'(10'h200));
        checkOutput("oor_main_ok", 64'(d0MainOk), 64'(0));
        checkOutput("oor_queue_empty", 64'(expQ.size()), 64'(0));

        // Paced instance: wait window and a byte injected during it.
        monSel = 1'b1;
        startDownload(8'd0);
        checkOutput("wait_err_cleared", 64'(d3LoadErr), 64'(0));
        applyStimulus(25'h0000, rndByte(), 1'b1, 1'b0);
        ioctlWr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_high", 64'(d3Wait), 64'(1));
            tick();
        end
        checkOutput("wait_low", 64'(d3Wait), 64'(0));
        applyStimulus(25'h0001, rndByte(), 1'b1, 1'b0);
        applyStimulus(25'h0002, rndByte(), 1'b0, 1'b0);
        ioctlWr = 1'b0;
        checkOutput("wait_violation_err", 64'(d3LoadErr), 64'(1));
        repeat (3) tick();
        ioctlDownload = 1'b0;
        repeat (2) tick();
        checkOutput("wait_main_ok", 64'(d3MainOk), 64'(0));
        checkOutput("wait_load_err", 64'(d3LoadErr), 64'(1));
        checkOutput("wait_queue_empty", 64'(expQ.size()), 64'(0));
        monSel = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a main download.
        startDownload(8'd0);
        applyStimulus(25'h0FFE, rndByte(), 1'b1, 1'b0);
        applyStimulus(25'h0FFF, rndByte(), 1'b1, 1'b0);
        ioctlWr = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("pre_reset_region", 64'(d0RegionDone), 64'(10'h001));
        resetN = 1'b0;
        #1;
        checkOutput("midrst_main_wr", 64'(d0MainWr), 64'(0));
        checkOutput("midrst_rom_addr", 64'(d0RomAddr), 64'(0));
        checkOutput("midrst_rom_data", 64'(d0RomData), 64'(0));
        checkOutput("midrst_region", 64'(d0RegionDone), 64'(0));
        checkOutput("midrst_load_err", 64'(d0LoadErr), 64'(0));
        checkOutput("midrst_wait", 64'(d0Wait), 64'(0));
        checkOutput("midrst_hold", 64'(d0Hold), 64'(1));
        #2;
        resetN = 1'b1;
        tick();
        for (int i = 'h10; i < 'h20; i++) applyStimulus(25'(i), rndByte(), 1'b0, 1'b0);
        ioctlWr = 1'b0;
        ioctlDownload = 1'b0;
        repeat (3) tick();
        checkOutput("postrst_region", 64'(d0RegionDone), 64'(0));
        checkOutput("postrst_main_ok", 64'(d0MainOk), 64'(0));
        checkOutput("postrst_load_err", 64'(d0LoadErr), 64'(0));
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
